// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CH event counters beside the MEM stage: per-channel enable,
// wrap/saturate overflow with sticky flags, and a freeze snapshot for coherent reads.
module perf_counter_bank #(
  parameter int          NUM_CH    = 8,
  parameter int          CNT_WIDTH = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFFC0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] event_inc,
  input  logic [15:0]       mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_wdata,
  output logic              hit,
  output logic [15:0]       rdata,
  output logic              ovf_any
);

  if (NUM_CH < 1 || NUM_CH > 16 || CNT_WIDTH < 1 || CNT_WIDTH > 16 || BASE_ADDR[0]) begin : g_param_err
    $error("perf_counter_bank: NUM_CH/CNT_WIDTH must be 1..16 and BASE_ADDR even");
  end

  localparam logic [15:0]          LAST_OFF = 16'(2 * NUM_CH + 5);
  localparam logic [14:0]          REG_CTRL = 15'(NUM_CH);
  localparam logic [14:0]          REG_EN   = 15'(NUM_CH + 1);
  localparam logic [14:0]          REG_OVF  = 15'(NUM_CH + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [15:0]          off;
  logic [14:0]          reg_idx;
  logic                 in_win;
  logic                 wr;

  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] snap_q [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic [NUM_CH-1:0]    en_q, en_d;
  logic                 freeze_q, freeze_d;
  logic                 gen_q, gen_d;
  logic                 snap_take;
  logic [CNT_WIDTH-1:0] cnt_rd;

  // Offset arithmetic wraps modulo 2^16, so addresses below the base land far out of range.
  assign off     = mem_addr - BASE_ADDR;
  assign reg_idx = off[15:1];
  assign in_win  = (off <= LAST_OFF);
  assign hit     = (mem_read | mem_write) & in_win;
  assign wr      = mem_write & in_win;
  assign ovf_any = |ovf_q;

  always_comb begin
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    en_d      = en_q;
    freeze_d  = freeze_q;
    gen_d     = gen_q;
    snap_take = 1'b0;
    if (wr) begin
      case (reg_idx)
        REG_CTRL: begin
          freeze_d  = mem_wdata[0];
          gen_d     = mem_wdata[1];
          snap_take = mem_wdata[0] & ~freeze_q;
        end
        REG_EN:  en_d  = mem_wdata[NUM_CH-1:0];
        REG_OVF: ovf_d = ovf_q & ~mem_wdata[NUM_CH-1:0];
        default: ;
      endcase
    end
    // Overflow sets are applied after the W1C clear so a same-cycle set survives.
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && reg_idx == 15'(i)) begin
        cnt_d[i] = mem_wdata[CNT_WIDTH-1:0];
      end else if (gen_q && en_q[i] && event_inc[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = SATURATE ? CNT_MAX : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (reg_idx == 15'(i)) cnt_rd = freeze_q ? snap_q[i] : cnt_q[i];
    end
    rdata = '0;
    if (hit) begin
      if (reg_idx < REG_CTRL)      rdata = 16'(cnt_rd);
      else if (reg_idx == REG_CTRL) rdata = {14'd0, gen_q, freeze_q};
      else if (reg_idx == REG_EN)   rdata = 16'(en_q);
      else                          rdata = 16'(ovf_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q    <= '0;
      en_q     <= '1;
      freeze_q <= 1'b0;
      gen_q    <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_take) snap_q[i] <= cnt_q[i];
      end
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      freeze_q <= freeze_d;
      gen_q    <= gen_d;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three configurations share one stimulus stream and are
// compared every cycle against an array-based reference model of the register map.
module tb_perf_counter_bank;

  localparam logic [15:0] BASE = 16'hFFC0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       ev;
  logic [15:0]      addr, wd;
  logic             rd, wr;
  logic [2:0]       hit_w, ovf_w;
  logic [2:0][15:0] rdv;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(8), .CNT_WIDTH(16), .BASE_ADDR(BASE), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .event_inc(ev), .mem_addr(addr), .mem_read(rd),
    .mem_write(wr), .mem_wdata(wd), .hit(hit_w[0]), .rdata(rdv[0]), .ovf_any(ovf_w[0]));
  perf_counter_bank #(.NUM_CH(8), .CNT_WIDTH(4), .BASE_ADDR(BASE), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .event_inc(ev), .mem_addr(addr), .mem_read(rd),
    .mem_write(wr), .mem_wdata(wd), .hit(hit_w[1]), .rdata(rdv[1]), .ovf_any(ovf_w[1]));
  perf_counter_bank #(.NUM_CH(5), .CNT_WIDTH(4), .BASE_ADDR(BASE), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .event_inc(ev[4:0]), .mem_addr(addr), .mem_read(rd),
    .mem_write(wr), .mem_wdata(wd), .hit(hit_w[2]), .rdata(rdv[2]), .ovf_any(ovf_w[2]));

  int NCH[3] = '{8, 8, 5};
  int CW[3]  = '{16, 4, 4};
  int SAT[3] = '{0, 0, 1};

  int m_cnt[3][16];
  int m_snap[3][16];
  int m_ovf[3], m_en[3], m_frz[3], m_gen[3];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_cnt[k][i]  = 0;
        m_snap[k][i] = 0;
      end
      m_ovf[k] = 0;
      m_en[k]  = (1 << NCH[k]) - 1;
      m_frz[k] = 0;
      m_gen[k] = 1;
    end
  endtask

  function automatic int reg_of(input int k, input int a, output bit inwin);
    int o;
    o = (a - int'(BASE)) & 'hFFFF;
    inwin = (o <= 2 * NCH[k] + 5);
    return o >> 1;
  endfunction

  function automatic int model_read(input int k, input int r);
    int n;
    n = NCH[k];
    if (r < n)      return m_frz[k] ? m_snap[k][r] : m_cnt[k][r];
    if (r == n)     return m_gen[k] * 2 + m_frz[k];
    if (r == n + 1) return m_en[k];
    return m_ovf[k];
  endfunction

  // One clock of the register-map rules, evaluated from the pre-edge state.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int  n, mx, mask, r, og, oe, nov;
      int  nc[16];
      bit  inw, w;
      n    = NCH[k];
      mx   = (1 << CW[k]) - 1;
      mask = (1 << n) - 1;
      r    = reg_of(k, int'(addr), inw);
      w    = wr && inw;
      og   = m_gen[k];
      oe   = m_en[k];
      nov  = m_ovf[k];
      for (int i = 0; i < 16; i++) nc[i] = m_cnt[k][i];
      if (w) begin
        if (r < n) nc[r] = int'(wd) & mx;
        else if (r == n) begin
          if (wd[0] && m_frz[k] == 0)
            for (int i = 0; i < 16; i++) m_snap[k][i] = m_cnt[k][i];
          m_frz[k] = int'(wd[0]);
          m_gen[k] = int'(wd[1]);
        end
        else if (r == n + 1) m_en[k] = int'(wd) & mask;
        else nov = m_ovf[k] & ~int'(wd) & mask;
      end
      for (int i = 0; i < n; i++) begin
        if (!(w && r == i) && og != 0 && oe[i] && ev[i]) begin
          if (m_cnt[k][i] == mx) begin
            nov   = nov | (1 << i);
            nc[i] = SAT[k] ? mx : 0;
          end else begin
            nc[i] = m_cnt[k][i] + 1;
          end
        end
      end
      for (int i = 0; i < 16; i++) m_cnt[k][i] = nc[i];
      m_ovf[k] = nov;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      bit inw;
      int r, h;
      r = reg_of(k, int'(addr), inw);
      h = ((rd | wr) && inw) ? 1 : 0;
      chk($sformatf("hit%0d", k), hit_w[k], h);
      chk($sformatf("rdata%0d@%h", k, addr), rdv[k], h ? model_read(k, r) : 0);
      chk($sformatf("ovf_any%0d", k), ovf_w[k], (m_ovf[k] != 0) ? 1 : 0);
    end
  endtask

  task automatic drive(input logic [7:0] e, input logic [15:0] a, input logic r,
                       input logic w, input logic [15:0] d);
    ev = e; addr = a; rd = r; wr = w; wd = d;
    #2;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic step(input logic [7:0] e, input logic [15:0] a, input logic r,
                      input logic w, input logic [15:0] d);
    drive(e, a, r, w, d);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ev = '0; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // T1: five pulses on channel 2, read back with same-cycle hit
    repeat (5) step(8'h04, 16'h0000, 1'b0, 1'b0, 16'h0);
    drive(8'h00, BASE + 16'd4, 1'b1, 1'b0, 16'h0);
    chk("T1 cnt2", rdv[0], 16'h0005);
    chk("T1 hit", hit_w[0], 1'b1);
    tick();

    // T2: 4-bit wrap, 17 pulses on channel 0, then W1C
    do_reset();
    repeat (17) step(8'h01, 16'h0000, 1'b0, 1'b0, 16'h0);
    drive(8'h00, BASE, 1'b1, 1'b0, 16'h0);
    chk("T2 cnt0 w4", rdv[1], 16'h0001);
    chk("T2 cnt0 w16", rdv[0], 16'h0011);
    tick();
    drive(8'h00, BASE + 16'd20, 1'b1, 1'b0, 16'h0);
    chk("T2 ovf", rdv[1], 16'h0001);
    chk("T2 ovf_any", ovf_w[1], 1'b1);
    tick();
    step(8'h00, BASE + 16'd20, 1'b0, 1'b1, 16'h0001);
    drive(8'h00, BASE + 16'd20, 1'b1, 1'b0, 16'h0);
    chk("T2 ovf clr", rdv[1], 16'h0000);
    chk("T2 ovf_any clr", ovf_w[1], 1'b0);
    tick();

    // T3: saturating 4-bit, 20 pulses on channel 1; W1C loses to a new overflow
    do_reset();
    repeat (20) step(8'h02, 16'h0000, 1'b0, 1'b0, 16'h0);
    drive(8'h00, BASE + 16'd2, 1'b1, 1'b0, 16'h0);
    chk("T3 sat cnt1", rdv[2], 16'h000F);
    tick();
    drive(8'h00, BASE + 16'd14, 1'b1, 1'b0, 16'h0);
    chk("T3 sat ovf", rdv[2], 16'h0002);
    tick();
    step(8'h02, BASE + 16'd14, 1'b0, 1'b1, 16'h0002);
    drive(8'h00, BASE + 16'd14, 1'b1, 1'b0, 16'h0);
    chk("T3 ovf reset", rdv[2], 16'h0002);
    tick();

    // T4: freeze snapshot at 10/20, live counters advance behind it
    do_reset();
    repeat (10) step(8'h03, 16'h0000, 1'b0, 1'b0, 16'h0);
    repeat (10) step(8'h02, 16'h0000, 1'b0, 1'b0, 16'h0);
    step(8'h00, BASE + 16'd16, 1'b0, 1'b1, 16'h0003);
    repeat (3) step(8'h03, 16'h0000, 1'b0, 1'b0, 16'h0);
    drive(8'h00, BASE, 1'b1, 1'b0, 16'h0);
    chk("T4 snap0", rdv[0], 16'd10);
    tick();
    drive(8'h00, BASE + 16'd2, 1'b1, 1'b0, 16'h0);
    chk("T4 snap1", rdv[0], 16'd20);
    tick();
    step(8'h00, BASE + 16'd16, 1'b0, 1'b1, 16'h0002);
    drive(8'h00, BASE, 1'b1, 1'b0, 16'h0);
    chk("T4 live0", rdv[0], 16'd13);
    tick();
    drive(8'h00, BASE + 16'd2, 1'b1, 1'b0, 16'h0);
    chk("T4 live1", rdv[0], 16'd23);
    tick();

    // T5: enable mask, global disable, write beats increment
    do_reset();
    step(8'h00, BASE + 16'd18, 1'b0, 1'b1, 16'h00FE);
    repeat (4) step(8'hFF, 16'h0000, 1'b0, 1'b0, 16'h0);
    drive(8'h00, BASE, 1'b1, 1'b0, 16'h0);
    chk("T5 ch0 masked", rdv[0], 16'd0);
    tick();
    step(8'h00, BASE + 16'd16, 1'b0, 1'b1, 16'h0000);
    repeat (3) step(8'hFF, 16'h0000, 1'b0, 1'b0, 16'h0);
    drive(8'h00, BASE + 16'd2, 1'b1, 1'b0, 16'h0);
    chk("T5 gen off", rdv[0], 16'd4);
    tick();
    step(8'h00, BASE + 16'd16, 1'b0, 1'b1, 16'h0002);
    step(8'hFF, BASE + 16'd6, 1'b0, 1'b1, 16'h0100);
    drive(8'h00, BASE + 16'd6, 1'b1, 1'b0, 16'h0);
    chk("T5 write wins", rdv[0], 16'h0100);
    tick();

    // T6: reset while frozen, overflowed and mid-store
    do_reset();
    repeat (16) step(8'h01, 16'h0000, 1'b0, 1'b0, 16'h0);
    step(8'h00, BASE + 16'd16, 1'b0, 1'b1, 16'h0003);
    step(8'h01, BASE, 1'b0, 1'b1, 16'h1234);
    drive(8'h01, BASE, 1'b0, 1'b1, 16'h1234);
    chk("T6 pre ovf_any", ovf_w[1], 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("T6 rst ovf_any", ovf_w, 3'b000);
    chk("T6 rst hit", hit_w[0], 1'b1);
    @(posedge clk);
    #3;
    check_all();
    wr = 1'b0;
    rst_n = 1'b1;
    tick();
    drive(8'h00, BASE + 16'd16, 1'b1, 1'b0, 16'h0);
    chk("T6 ctrl", rdv[0], 16'h0002);
    tick();
    drive(8'h00, BASE + 16'd18, 1'b1, 1'b0, 16'h0);
    chk("T6 en", rdv[0], 16'h00FF);
    tick();
    drive(8'h00, BASE - 16'd2, 1'b1, 1'b0, 16'h0);
    chk("T6 below hit", hit_w, 3'b000);
    chk("T6 below rdata", rdv[0], 16'h0);
    tick();
    drive(8'h00, BASE + 16'd22, 1'b1, 1'b1, 16'hFFFF);
    chk("T6 above hit", hit_w[0], 1'b0);
    chk("T6 above rdata", rdv[0], 16'h0);
    tick();
    drive(8'h00, BASE + 16'd21, 1'b1, 1'b0, 16'h0);
    chk("T6 last byte hit", hit_w[0], 1'b1);
    tick();

    // Randomized traffic with stalled (repeated) accesses and occasional resets
    for (int it = 0; it < 2500; it++) begin
      logic [7:0]  e;
      logic [15:0] a, d;
      logic        r, w;
      int          kind;
      e    = 8'($urandom);
      kind = $urandom_range(0, 3);
      a    = BASE - 16'd4 + 16'($urandom_range(0, 30));
      d    = 16'($urandom);
      d[1] = ($urandom_range(0, 3) != 0);
      r    = (kind == 2);
      w    = (kind == 3);
      repeat ($urandom_range(1, 3)) step(e, a, r, w, d);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
